// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: one word per handshake, shifted out MSB first.
// Define PISO_PARITY_EN to append an even-parity beat after the data bits.
module piso_serializer #(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [size-1:0] dataIn,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(size);
    localparam logic [CW-1:0] LAST_BEAT = CW'(size - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t          state_r;
    logic [size-1:0] shreg_r;
    logic [CW-1:0]   cnt_r;
    logic            done_r;
`ifdef PISO_PARITY_EN
    logic            par_r;

    // Even parity: the appended bit makes the XOR of all transmitted bits zero.
    function automatic logic even_parity(input logic [size-1:0] word);
        return ^word;
    endfunction
`endif

    // Control FSM, shift register, beat counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_r <= IDLE;
            shreg_r <= '0;
            cnt_r   <= '0;
            done_r  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        shreg_r <= dataIn;
                        cnt_r   <= '0;
                        state_r <= SHIFT;
`ifdef PISO_PARITY_EN
                        par_r   <= even_parity(dataIn);
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        shreg_r <= {shreg_r[size-2:0], 1'b0};
                        cnt_r   <= cnt_r + CW'(1);
                        if (cnt_r == LAST_BEAT) begin
`ifdef PISO_PARITY_EN
                            state_r <= PAR;
`else
                            state_r <= IDLE;
                            done_r  <= 1'b1;
`endif
                        end else begin
                            state_r <= SHIFT;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
`ifdef PISO_PARITY_EN
                PAR: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= PAR;
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Serial bit selection, decoded from registered state only.
    always_comb begin
        out_bit = 1'b0;
        case (state_r)
            SHIFT:   out_bit = shreg_r[size-1];
`ifdef PISO_PARITY_EN
            PAR:     out_bit = par_r;
`endif
            default: out_bit = 1'b0;
        endcase
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = (state_r != IDLE);
    assign done      = done_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: vector table, directed corner sequences,
// and randomized traffic checked against a queue-of-bits reference model.
module tb_piso_serializer;

    localparam int SIZE = 8;
`ifdef PISO_PARITY_EN
    localparam int PAR_BEATS = 1;
`else
    localparam int PAR_BEATS = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [SIZE-1:0] dataIn = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_bit;
    logic            busy;
    logic            done;

    piso_serializer #(.size(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataIn    (dataIn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int beats = 0;
    logic [15:0] rx = '0;

    // Reference model: the bits still to be sent for the current word, front first.
    logic q[$];
    logic m_done = 1'b0;

    typedef struct {
        logic            r;
        logic            c;
        logic            iv;
        logic [SIZE-1:0] d;
        logic            ordy;
        logic [4:0]      exp; // {in_ready, busy, out_valid, out_bit, done}
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic c, input logic iv,
                                input logic [SIZE-1:0] d, input logic ordy);
        m_done = 1'b0;
        if (r || c) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (iv) begin
                for (int i = SIZE - 1; i >= 0; i--) q.push_back(d[i]);
                if (PAR_BEATS == 1) q.push_back(^d);
            end
        end else if (ordy) begin
            void'(q.pop_front());
            if (q.size() == 0) m_done = 1'b1;
        end
    endtask

    function automatic logic [4:0] model_outs();
        logic empty;
        empty = (q.size() == 0);
        return {empty, !empty, !empty, empty ? 1'b0 : q[0], m_done};
    endfunction

    task automatic step(input logic r, input logic c, input logic iv,
                        input logic [SIZE-1:0] d, input logic ordy);
        logic pre_ov;
        logic pre_bit;
        pre_ov  = out_valid;
        pre_bit = out_bit;
        rst = r; clear = c; in_valid = iv; dataIn = d; out_ready = ordy;
        @(posedge clk);
        #1;
        if (pre_ov === 1'b1 && ordy && !r && !c) begin
            beats++;
            rx = {rx[14:0], pre_bit};
        end
        if (done === 1'b1) done_seen++;
        model_update(r, c, iv, d, ordy);
        check("model", {11'd0, in_ready, busy, out_valid, out_bit, done}, {11'd0, model_outs()});
    endtask

    task automatic run_until_done(input string name, input int pattern);
        logic ordy;
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (pattern == 1) ordy = (i % 4 == 0) || (i % 4 == 3);
            else ordy = 1'b1;
            step(1'b0, 1'b0, 1'b0, 8'h00, ordy);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check(name, {15'd0, got}, 16'd1);
    endtask

    initial begin
        int d0;
        logic [15:0] exp_w;

        // Reset with a word offered, then load 8'hA5 and watch the first 8 bits.
        vecs[0] = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 5'b10000};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 5'b10000};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 5'b01110};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'b01100};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 5'b01110};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'b01100};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'b01100};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'b01110};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'b01100};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'b01110};
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].r, vecs[i].c, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            check($sformatf("vec%0d", i), {11'd0, in_ready, busy, out_valid, out_bit, done},
                  {11'd0, vecs[i].exp});
        end

        // Final beat of 8'hA5: done next, or parity bit 0 first.
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef PISO_PARITY_EN
        check("a5_parity_bit", {15'd0, out_bit}, 16'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`endif
        check("a5_done", {14'd0, done, in_ready}, 16'b11);

        // Clear together with in_valid while idle: word not accepted.
        step(1'b0, 1'b1, 1'b1, 8'hAA, 1'b1);
        check("clear_wins", {13'd0, in_ready, busy, done}, 16'b100);

        // Backpressure on 8'h81.
        step(1'b0, 1'b0, 1'b1, 8'h81, 1'b0);
        beats = 0; rx = '0;
        run_until_done("bp_done", 1);
        check("bp_beats", 16'(beats), 16'(SIZE + PAR_BEATS));
        exp_w = (PAR_BEATS == 1) ? {7'd0, 8'h81, ^8'h81} : {8'd0, 8'h81};
        check("bp_bits", rx & ((16'd1 << (SIZE + PAR_BEATS)) - 16'd1), exp_w);

        // Back-to-back 8'h0F then 8'hF0 accepted in the done cycle.
        d0 = done_seen;
        step(1'b0, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_until_done("b2b_done1", 0);
        step(1'b0, 1'b0, 1'b1, 8'hF0, 1'b1);
        check("b2b_first_bit", {14'd0, out_valid, out_bit}, 16'b11);
        run_until_done("b2b_done2", 0);
        check("b2b_pulses", 16'(done_seen - d0), 16'd2);

        // Abort 8'h3C after 3 beats, then 8'hC3 must serialize cleanly.
        d0 = done_seen;
        step(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        check("abort_idle", {13'd0, out_valid, in_ready, busy}, 16'b010);
        check("abort_no_done", 16'(done_seen - d0), 16'd0);
        step(1'b0, 1'b0, 1'b1, 8'hC3, 1'b1);
        beats = 0; rx = '0;
        run_until_done("c3_done", 0);
        exp_w = (PAR_BEATS == 1) ? {7'd0, 8'hC3, ^8'hC3} : {8'd0, 8'hC3};
        check("c3_bits", rx & ((16'd1 << (SIZE + PAR_BEATS)) - 16'd1), exp_w);

`ifdef PISO_PARITY_EN
        step(1'b0, 1'b0, 1'b1, 8'h07, 1'b1);
        beats = 0; rx = '0;
        run_until_done("p07_done", 0);
        check("p07_parity", {15'd0, rx[0]}, 16'd1);
`endif

        // Reset mid-word aborts with no done.
        d0 = done_seen;
        step(1'b0, 1'b0, 1'b1, 8'hE7, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_mid", {12'd0, in_ready, busy, out_valid, out_bit}, 16'b1000);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_no_done", 16'(done_seen - d0), 16'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 60) == 0, ($urandom % 30) == 0, $urandom % 2,
                 8'($urandom), ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that accepts one `size`-bit word per handshake and drives it out one bit per accepted beat, MSB first. It is the read-out end of the datapath's parallel registers: words captured by load/clear registers are drained onto a 1-bit link. A one-cycle `done` pulse marks each completed word, and an optional even-parity bit can follow the data bits.

## Interface
Parameters:
- `size`, default 8: word width in bits; legal values are 2 and above.

Ports:
- `clk`  in  1  Single clock; all state changes on its rising edge.
- `rst`  in  1  Synchronous, active-high reset. Sampled on the `clk` rising edge and has highest priority.
- `clear`  in  1  Synchronous abort. Returns the block to IDLE. Lower priority than `rst`, higher than everything else.
- `in_valid`  in  1  Parallel word offered.
- `in_ready`  out  1  Block can accept a word. Equals (state == IDLE).
- `dataIn`  in  `size`  Word to serialize. Sampled only on the accept edge.
- `out_valid`  out  1  `out_bit` is valid.
- `out_ready`  in  1  Downstream consumes `out_bit`.
- `out_bit`  out  1  Current serial bit.
- `busy`  out  1  High whenever state != IDLE.
- `done`  out  1  Registered one-cycle pulse after the last beat of a word is accepted.

## Operation
- States: IDLE, SHIFT, PAR (PAR exists only with the parity macro).
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid & in_ready`: the shift register loads `dataIn`, the counter loads 0, and the state moves to SHIFT.
  - With parity enabled, the parity register loads ^`dataIn` in the same edge.
- SHIFT:
  - `out_valid`=1 and `out_bit` = shreg[size-1].
  - On `out_valid & out_ready`: shreg shifts left with 0 fill, and the counter increments.
  - On the beat where counter == size-1, the next state is PAR if parity is enabled, otherwise IDLE.
- PAR:
  - `out_valid`=1 and `out_bit` = parity register.
  - On `out_ready` the state moves to IDLE.
- Counter width is $clog2(size). Its increment never wraps within a word.
- `done` is set on the same edge that performs the final-beat transition to IDLE. It is cleared on every other edge.
- `out_bit` is 0 whenever `out_valid`=0.
- `clear` in any state:
  - Next state IDLE; shreg, counter and parity register go to 0.
  - `done` is not pulsed, and any in-flight word is discarded.
- `clear` and `in_valid` in the same cycle: clear wins and the word is not accepted. `in_ready` still reads 1 that cycle if the block is already in IDLE.
- Changes to `dataIn` while the block is not in IDLE are ignored.
- The block holds state indefinitely while `out_ready`=0. `out_bit` stays stable for as long as `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values (cycle after a `rst` edge):
  - state IDLE; shreg, counter and parity register 0.
  - `in_ready`=1, `out_valid`=0, `out_bit`=0, `busy`=0, `done`=0.
- `rst` asserted mid-word aborts immediately, exactly like `clear`, with no `done`.
- Accept at edge k puts `out_valid`=1 and the MSB on `out_bit` in cycle k+1.
- With `out_ready` held at 1, a word takes `size` beats without parity or `size`+1 beats with parity. `done`=1 and `in_ready`=1 in the cycle after the final beat.
- Back-to-back words: the next word can be accepted in the same cycle `done` is high. That gives one idle cycle between words, so throughput is `size`+1 cycles per word without parity.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `PISO_PARITY_EN` defined:
  - PAR state and the parity register are compiled in.
  - One extra beat carries the even parity bit, so XOR of all transmitted bits = 0.
- `PISO_PARITY_EN` undefined:
  - Neither the PAR state nor the parity register exists.
  - A word is exactly `size` beats, and SHIFT goes directly to IDLE.

## Test plan
- Reset: assert `rst` for 2 cycles while `in_valid`=1 and `dataIn`=8'hFF. Required: `in_ready`=1, `busy`=0, `out_valid`=0, `done`=0, and no word accepted.
- Basic serialize (size=8): load 8'hA5 with `out_ready`=1. Required: `out_bit` sequence 1,0,1,0,0,1,0,1 on cycles k+1..k+8 and `done`=1 at k+9. With `PISO_PARITY_EN`, beat 9 carries 0 and `done` moves to k+10.
- Backpressure: load 8'h81 and toggle `out_ready` 1,0,0,1,… Required: `out_bit` holds while stalled, exactly 8 (or 9 with parity) accepted beats, and order MSB-first.
- Back-to-back words: load 8'h0F, then 8'hF0 in the `done` cycle. Required: the second word's first bit (1) appears the next cycle and two `done` pulses occur.
- Abort: load 8'h3C, then assert `clear` after 3 beats. Required: IDLE the next cycle with `out_valid`=0, `done` never asserted, and the next word 8'hC3 serializes cleanly.
- Parity, `PISO_PARITY_EN` only: load 8'h07. Required: parity beat = 1.
